fft_spi_tx: RTL and testbench
=============================

FFT_SPI_TX -- requirements
Module: fft_spi_tx

Interface
REQ-001 The block SHALL have parameter BUF_W, default 1024, giving the result buffer width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 11, giving the bit counter width; it SHALL satisfy 2^CNT_W > BUF_W.
REQ-003 Port clk, input, 1: the single system clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-low reset.
REQ-005 Port fft_out1024, input, BUF_W: result buffer from the FFT output flop.
REQ-006 Port buf_ready, input, 1: level; high means fft_out1024 is valid and unread.
REQ-007 Port sck, input, 1: SPI clock from the MCU, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-008 Port cs, input, 1: SPI chip select from the MCU, active-low, asynchronous to clk.
REQ-009 Port sdo, output, 1: SPI serial data to the MCU.
REQ-010 Port data_ready, output, 1: level; high means a result is latched and awaiting readout.
REQ-011 Port buf_empty, output, 1: one-clk pulse; the full buffer has been read out.
REQ-012 Port tx_abort, output, 1: one-clk pulse; cs deasserted before BUF_W bits were sent.

Function
REQ-013 sck and cs SHALL each pass through a two-flop synchronizer, plus a third flop for edge detection.
- Synchronizer flops reset to sck=0, cs=1.
REQ-014 FSM states SHALL be IDLE, LOADED, SHIFT, DONE.
REQ-015 IDLE: when buf_ready=1, the block SHALL copy fft_out1024 into a BUF_W shift register, clear the bit counter, and enter LOADED on the next clk.
REQ-016 IDLE: a synchronized cs falling edge with buf_ready=0 SHALL be ignored.
- It SHALL NOT start a transfer later.
REQ-017 LOADED: data_ready SHALL be 1.
- A synchronized cs falling edge SHALL enter SHIFT.
- buf_ready SHALL be ignored.
REQ-018 SHIFT: sdo SHALL equal shift register bit BUF_W-1 (MSB first; fft_out1024[BUF_W-1] is the first bit sent).
REQ-019 SHIFT: each synchronized sck rising edge SHALL increment the bit counter.
- The counter SHALL saturate at BUF_W.
REQ-020 SHIFT: each synchronized sck falling edge SHALL shift the register left by one and fill the LSB with 0.
- This SHALL occur only while the counter < BUF_W.
REQ-021 SHIFT: after BUF_W rising edges, sdo SHALL be 0 and further sck edges SHALL have no effect.
REQ-022 SHIFT: a synchronized cs rising edge with counter = BUF_W SHALL enter DONE.
REQ-023 SHIFT: a synchronized cs rising edge with counter < BUF_W SHALL enter IDLE and pulse tx_abort for one clk.
- buf_empty SHALL NOT pulse.
- The data SHALL be discarded.
REQ-024 DONE: buf_empty SHALL pulse for exactly one clk, then the FSM SHALL enter IDLE.
REQ-025 If buf_ready is still 1 on the IDLE cycle after DONE, a new load SHALL occur (REQ-015).
- This is a one-clk bubble; a simultaneous load and complete is not possible.
REQ-026 data_ready SHALL be 1 in LOADED and SHIFT, and 0 in IDLE and DONE.
REQ-027 sdo SHALL be 0 whenever the state is not SHIFT.
REQ-028 Correct operation SHALL require the sck frequency to be at most f_clk/8, and cs setup/hold to be at least 4 clk periods around the sck edges.
REQ-029 Latency SHALL be as follows.
- Load: buf_ready high to data_ready high is 1 clk.
- cs fall: pin to valid MSB on sdo is at most 4 clk.
- Shift: sck fall pin to next bit on sdo is at most 4 clk.
- Completion: cs rise pin to buf_empty is at most 5 clk.

Reset
REQ-030 reset=0 SHALL, asynchronously and without waiting for clk, force the following.
- FSM to IDLE.
- Shift register and bit counter to 0.
- sdo=0, data_ready=0, buf_empty=0, tx_abort=0.
REQ-031 Reset asserted mid-SHIFT SHALL discard the transfer without pulsing buf_empty or tx_abort.
REQ-032 After reset release, the first load SHALL need buf_ready=1 sampled on a clk edge.

Verification
REQ-033 Load and full read:
- Stimulus: fft_out1024 = {64{16'hA5C3}}, buf_ready=1, cs low, 1024 sck pulses at clk/10, cs high.
- Response: 1024 bits captured on sck rise equal the input MSB-first; buf_empty pulses exactly once; data_ready drops.
REQ-034 Abort:
- Stimulus: cs high after 100 sck pulses.
- Response: tx_abort pulses once; no buf_empty; state IDLE; sdo=0.
REQ-035 Early cs:
- Stimulus: cs falls with buf_ready=0, then buf_ready rises 50 clk later.
- Response: sdo stays 0; data_ready goes 1 after 1 clk; a new cs fall then reads the data correctly.
REQ-036 Overrun:
- Stimulus: 1030 sck pulses within one cs frame.
- Response: bits 1025-1030 read 0; buf_empty pulses once.
REQ-037 Back-to-back:
- Stimulus: buf_ready held high across completion, with a different buffer (e.g. {BUF_W/16{16'h0001}}).
- Response: reload occurs 1 clk after the DONE cycle; the second read returns the new data.
REQ-038 Reset mid-transfer:
- Stimulus: reset=0 asynchronously after 512 sck pulses.
- Response: all outputs 0 immediately; no pulses; normal load resumes after release.

Source files
------------

// File: rtl/fft_spi_tx.sv
// fft_spi_tx: holds one FFT result buffer and streams it MSB-first to an SPI
// master (mode 0, chip select active-low). sck and cs come from the MCU and
// are asynchronous to clk. Each one is synchronized with two flops. A third
// flop provides edge detection, so every edge is handled in the clk domain.
// CNT_W must satisfy 2**CNT_W > BUF_W so that the counter can hold BUF_W.
`timescale 1ns/1ps
module fft_spi_tx #(
   parameter int BUF_W = 1024,
   parameter int CNT_W = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [BUF_W-1:0] fft_out1024,
   input  logic             buf_ready,
   input  logic             sck,
   input  logic             cs,
   output logic             sdo,
   output logic             data_ready,
   output logic             buf_empty,
   output logic             tx_abort
);

   typedef enum logic [1:0] {IDLE, LOADED, SHIFT, DONE} state_t;

   // Counter value once every bit has been clocked out, and the value just before it
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUF_W - 1);

   state_t             state;
   logic [BUF_W-1:0]   shreg;
   logic [CNT_W-1:0]   cnt;

   // Synchronizer and edge-detect stages: _p0/_p1 synchronize, _p2 is the previous value
   logic sck_p0, sck_p1, sck_p2;
   logic cs_p0, cs_p1, cs_p2;

   logic sck_rise, sck_fall, cs_rise, cs_fall, cnt_full;

   // Bring sck and cs into the clk domain; idle levels are sck low, cs high
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sck_p0 <= 1'b0;
         sck_p1 <= 1'b0;
         sck_p2 <= 1'b0;
         cs_p0  <= 1'b1;
         cs_p1  <= 1'b1;
         cs_p2  <= 1'b1;
      end else begin
         sck_p0 <= sck;
         sck_p1 <= sck_p0;
         sck_p2 <= sck_p1;
         cs_p0  <= cs;
         cs_p1  <= cs_p0;
         cs_p2  <= cs_p1;
      end
   end

   assign sck_rise = sck_p1 & ~sck_p2;
   assign sck_fall = ~sck_p1 & sck_p2;
   assign cs_rise  = cs_p1 & ~cs_p2;
   assign cs_fall  = ~cs_p1 & cs_p2;
   assign cnt_full = (cnt == CNT_FULL);

   // Transfer FSM. All outputs are registered, so sdo is loaded with the bit that
   // the shift register will present after this edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         shreg      <= '0;
         cnt        <= '0;
         sdo        <= 1'b0;
         data_ready <= 1'b0;
         buf_empty  <= 1'b0;
         tx_abort   <= 1'b0;
      end else begin
         buf_empty <= 1'b0;
         tx_abort  <= 1'b0;
         unique case (state)
            IDLE: begin
               sdo        <= 1'b0;
               data_ready <= 1'b0;
               // A cs fall seen here is deliberately dropped; only a fresh fall after loading starts a read
               if (buf_ready) begin
                  shreg      <= fft_out1024;
                  cnt        <= '0;
                  data_ready <= 1'b1;
                  state      <= LOADED;
               end
            end
            LOADED: begin
               if (cs_fall) begin
                  sdo   <= shreg[BUF_W-1];
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (cs_rise) begin
                  sdo        <= 1'b0;
                  data_ready <= 1'b0;
                  if (cnt_full) begin
                     buf_empty <= 1'b1;
                     state     <= DONE;
                  end else begin
                     tx_abort <= 1'b1;
                     shreg    <= '0;
                     state    <= IDLE;
                  end
               end else if (sck_rise && !cnt_full) begin
                  cnt <= cnt + CNT_W'(1);
                  // The last bit has been sampled; the overrun bits read as zero
                  if (cnt == CNT_LAST) begin
                     sdo <= 1'b0;
                  end
               end else if (sck_fall && !cnt_full) begin
                  shreg <= {shreg[BUF_W-2:0], 1'b0};
                  sdo   <= shreg[BUF_W-2];
               end
            end
            DONE: begin
               // One-cycle gap so that a completion and a reload never happen on the same edge
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_spi_tx.sv
// Bench for fft_spi_tx. A scoreboard holds the expected sdo bits and the
// expected end-of-frame pulses. Stimulus pushes an entry for each sck pulse and
// each cs release it issues. Two monitors pop those entries when sck rises and
// when a pulse appears on buf_empty or tx_abort.
`timescale 1ns/1ps
module tb_fft_spi_tx;
   localparam int BUF_W = 1024;
   localparam int CNT_W = 11;
   localparam logic [1:0] EV_EMPTY = 2'b10;
   localparam logic [1:0] EV_ABORT = 2'b01;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [BUF_W-1:0] fft_out1024 = '0;
   logic             buf_ready = 1'b0;
   logic             sck = 1'b0;
   logic             cs = 1'b1;
   logic             sdo, data_ready, buf_empty, tx_abort;

   int checks = 0;
   int failures = 0;
   int bit_idx = 0;
   bit exp_bits[$];
   logic [1:0] exp_ev[$];
   bit exp_b;
   logic [1:0] exp_e;

   fft_spi_tx #(.BUF_W(BUF_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .fft_out1024(fft_out1024), .buf_ready(buf_ready),
      .sck(sck), .cs(cs), .sdo(sdo), .data_ready(data_ready),
      .buf_empty(buf_empty), .tx_abort(tx_abort)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: the bit the master sees at pulse i is the buffer MSB-first, then zeros
   function automatic bit model_bit(input logic [BUF_W-1:0] b, input int i);
      return (i < BUF_W) ? b[BUF_W-1-i] : 1'b0;
   endfunction

   // Reference model: a frame ends in completion when all bits were clocked, otherwise in an abort
   function automatic logic [1:0] model_end(input int n);
      return (n >= BUF_W) ? EV_EMPTY : EV_ABORT;
   endfunction

   function automatic logic [BUF_W-1:0] rand_buf();
      logic [BUF_W-1:0] b;
      for (int i = 0; i < BUF_W / 32; i++) b[i*32 +: 32] = $urandom();
      return b;
   endfunction

   // Master samples sdo on every sck rise inside a frame
   always @(posedge sck) begin
      if (cs === 1'b0 && reset === 1'b1) begin
         if (exp_bits.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sdo_unexpected_bit actual=%0b required=none", sdo);
         end else begin
            exp_b = exp_bits.pop_front();
            check($sformatf("sdo_bit%0d", bit_idx), sdo, exp_b);
         end
         bit_idx++;
      end
   end

   // Every clk with a buf_empty or tx_abort pulse must match the next expected event
   always @(negedge clk) begin
      if (buf_empty === 1'b1 || tx_abort === 1'b1) begin
         if (exp_ev.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse actual=%0b required=none", {buf_empty, tx_abort});
         end else begin
            exp_e = exp_ev.pop_front();
            check("end_pulse", {buf_empty, tx_abort}, exp_e);
         end
      end
   end

   task automatic load(input logic [BUF_W-1:0] b, input bit hold);
      @(negedge clk);
      fft_out1024 = b;
      buf_ready = 1'b1;
      @(negedge clk);
      check("load_data_ready", data_ready, 1'b1);
      check("loaded_sdo", sdo, 1'b0);
      if (!hold) buf_ready = 1'b0;
   endtask

   task automatic pulses(input logic [BUF_W-1:0] b, input int start, input int n, input int half);
      for (int i = start; i < start + n; i++) begin
         exp_bits.push_back(model_bit(b, i));
         sck = 1'b1;
         repeat (half) @(negedge clk);
         sck = 1'b0;
         repeat (half) @(negedge clk);
      end
   endtask

   task automatic frame_open();
      @(negedge clk);
      bit_idx = 0;
      cs = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic frame_close(input int n);
      repeat (2) @(negedge clk);
      exp_ev.push_back(model_end(n));
      cs = 1'b1;
   endtask

   task automatic frame(input logic [BUF_W-1:0] b, input int n, input int half);
      frame_open();
      pulses(b, 0, n, half);
      frame_close(n);
   endtask

   task automatic drain(input string tag);
      repeat (12) @(negedge clk);
      check({tag, "_bits_left"}, exp_bits.size(), 0);
      check({tag, "_events_left"}, exp_ev.size(), 0);
      check({tag, "_data_ready"}, data_ready, 1'b0);
      check({tag, "_sdo"}, sdo, 1'b0);
      exp_bits.delete();
      exp_ev.delete();
   endtask

   initial begin
      logic [BUF_W-1:0] a, b;
      int k;

      // Reset state
      #2 reset = 1'b0;
      #1;
      check("rst_sdo", sdo, 1'b0);
      check("rst_data_ready", data_ready, 1'b0);
      check("rst_buf_empty", buf_empty, 1'b0);
      check("rst_tx_abort", tx_abort, 1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      check("idle_no_load", data_ready, 1'b0);

      // Full read of the pattern buffer at clk/10
      load({64{16'hA5C3}}, 1'b0);
      frame({64{16'hA5C3}}, BUF_W, 5);
      drain("full_read");

      // Abort after 100 pulses
      a = rand_buf();
      load(a, 1'b0);
      frame(a, 100, $urandom_range(4, 6));
      drain("abort");

      // cs falls before any data; it must not start a transfer
      @(negedge clk);
      cs = 1'b0;
      for (int i = 0; i < 5; i++) begin
         repeat (10) @(negedge clk);
         check("early_cs_sdo", sdo, 1'b0);
         check("early_cs_data_ready", data_ready, 1'b0);
      end
      a = rand_buf();
      load(a, 1'b0);
      repeat (4) @(negedge clk);
      check("early_cs_still_loaded_sdo", sdo, 1'b0);
      cs = 1'b1;
      repeat (5) @(negedge clk);
      frame(a, BUF_W, 4);
      drain("early_cs_read");

      // Overrun: 1030 pulses in one frame
      a = rand_buf();
      load(a, 1'b0);
      frame(a, BUF_W + 6, 4);
      drain("overrun");

      // Back-to-back: buf_ready held across completion, new data presented meanwhile
      a = rand_buf();
      b = {BUF_W/16{16'h0001}};
      load(a, 1'b1);
      @(negedge clk);
      fft_out1024 = b;
      frame(a, BUF_W, 4);
      k = 0;
      while (buf_empty !== 1'b1 && k < 10) begin
         @(negedge clk);
         k++;
      end
      check("b2b_empty_seen", buf_empty, 1'b1);
      @(negedge clk);
      check("b2b_idle_gap", data_ready, 1'b0);
      @(negedge clk);
      check("b2b_reload", data_ready, 1'b1);
      buf_ready = 1'b0;
      frame(b, BUF_W, 4);
      drain("b2b_second");

      // Reset in the middle of a transfer
      a = rand_buf();
      load(a, 1'b0);
      frame_open();
      pulses(a, 0, 512, 4);
      #3 reset = 1'b0;
      #1;
      check("midrst_sdo", sdo, 1'b0);
      check("midrst_data_ready", data_ready, 1'b0);
      check("midrst_buf_empty", buf_empty, 1'b0);
      check("midrst_tx_abort", tx_abort, 1'b0);
      cs = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("midrst_no_load", data_ready, 1'b0);
      drain("midrst");
      a = rand_buf();
      load(a, 1'b0);
      frame(a, BUF_W, 4);
      drain("after_rst");

      // Randomized short aborted frames
      for (int f = 0; f < 3; f++) begin
         a = rand_buf();
         load(a, 1'b0);
         frame(a, $urandom_range(1, 200), $urandom_range(4, 6));
         drain("rand_abort");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Bound the whole run
   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
